// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the ALU sharing arbiter: ALU op codes, FSM state encoding
// and a small op-class helper.
package alu_pkg;

   localparam logic [3:0] ALU_AND  = 4'b0000;
   localparam logic [3:0] ALU_OR   = 4'b0001;
   localparam logic [3:0] ALU_ADD  = 4'b0010;
   localparam logic [3:0] ALU_XOR  = 4'b0011;
   localparam logic [3:0] ALU_SLL  = 4'b0100;
   localparam logic [3:0] ALU_SRL  = 4'b0101;
   localparam logic [3:0] ALU_SUB  = 4'b0110;
   localparam logic [3:0] ALU_SRA  = 4'b0111;
   localparam logic [3:0] ALU_SLT  = 4'b1000;
   localparam logic [3:0] ALU_SLTU = 4'b1001;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_EXEC = 2'b01,
      ST_RESP = 2'b10
   } arb_state_t;

   // Only arithmetic ops carry meaningful carry/overflow out of the ALU.
   function automatic logic is_addsub(input logic [3:0] op);
      return (op == ALU_ADD) || (op == ALU_SUB);
   endfunction

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Requester, response and ALU-side signals of the ALU sharing arbiter.
// rsp_flags exists only when ALU_FLAG_RETURN_EN is defined.
interface alu_share_arbiter_if #(
   parameter int NUM_REQ = 2,
   parameter int XLEN    = 64
);
   logic [NUM_REQ-1:0]      req_valid;
   logic [NUM_REQ-1:0]      req_ready;
   logic [4*NUM_REQ-1:0]    req_op;
   logic [XLEN*NUM_REQ-1:0] req_rs1;
   logic [XLEN*NUM_REQ-1:0] req_rs2;
   logic [NUM_REQ-1:0]      rsp_valid;
   logic [NUM_REQ-1:0]      rsp_ready;
   logic [XLEN-1:0]         rsp_rd;
`ifdef ALU_FLAG_RETURN_EN
   logic [2:0]              rsp_flags;
`endif
   logic [XLEN-1:0]         alu_rs1;
   logic [XLEN-1:0]         alu_rs2;
   logic [3:0]              alu_control;
   logic [XLEN-1:0]         alu_rd;
   logic                    alu_zero;
   logic                    alu_carry;
   logic                    alu_overflow;
   logic                    busy;

   modport slave (
      input  req_valid, req_op, req_rs1, req_rs2, rsp_ready,
             alu_rd, alu_zero, alu_carry, alu_overflow,
      output req_ready, rsp_valid, rsp_rd, alu_rs1, alu_rs2, alu_control, busy
`ifdef ALU_FLAG_RETURN_EN
      , output rsp_flags
`endif
   );

   modport master (
      output req_valid, req_op, req_rs1, req_rs2, rsp_ready,
             alu_rd, alu_zero, alu_carry, alu_overflow,
      input  req_ready, rsp_valid, rsp_rd, alu_rs1, alu_rs2, alu_control, busy
`ifdef ALU_FLAG_RETURN_EN
      , input rsp_flags
`endif
   );

endinterface

// File: rtl/alu_share_arbiter_rr_arbiter.sv
// Round-robin pick: first asserted request at or after the pointer, wrapping.
// Produces the one-hot grant, its index and an any-request flag.
module rr_arbiter
   import alu_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int IW      = 1
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [IW-1:0]      i_ptr,
   output logic [NUM_REQ-1:0] o_grant,
   output logic [IW-1:0]      o_idx,
   output logic               o_any
);

   function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int ofs);
      int s;
      s = int'(base) + ofs;
      if (s >= NUM_REQ) s = s - NUM_REQ;
      return IW'(s);
   endfunction

   always_comb begin
      o_grant = '0;
      o_idx   = '0;
      o_any   = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!o_any && i_req[wrap_add(i_ptr, k)]) begin
            o_any                      = 1'b1;
            o_idx                      = wrap_add(i_ptr, k);
            o_grant[wrap_add(i_ptr, k)] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU among NUM_REQ requesters: round-robin accept, one op in
// flight (IDLE -> EXEC -> RESP). Optional flag return under macro ALU_FLAG_RETURN_EN.
module alu_share_arbiter
   import alu_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int XLEN    = 64
) (
   input logic               clk,
   input logic               rst,
   alu_share_arbiter_if.slave bus
);

   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   arb_state_t         r_state;
   logic [IW-1:0]      r_ptr;
   logic [NUM_REQ-1:0] r_grant;
   logic [NUM_REQ-1:0] r_rsp_valid;
   logic [3:0]         r_op;
   logic [XLEN-1:0]    r_rs1;
   logic [XLEN-1:0]    r_rs2;
   logic [XLEN-1:0]    r_rd;
   logic               r_busy;

   logic [NUM_REQ-1:0] w_grant;
   logic [IW-1:0]      w_gidx;
   logic               w_any;
   logic               w_rsp_hs;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IW      (IW)
   ) u_rr (
      .i_req   (bus.req_valid),
      .i_ptr   (r_ptr),
      .o_grant (w_grant),
      .o_idx   (w_gidx),
      .o_any   (w_any)
   );

   assign w_rsp_hs      = |(r_rsp_valid & bus.rsp_ready);
   assign bus.req_ready = (r_state == ST_IDLE) ? w_grant : '0;
   assign bus.rsp_valid = r_rsp_valid;
   assign bus.rsp_rd    = r_rd;
   assign bus.alu_rs1   = r_rs1;
   assign bus.alu_rs2   = r_rs2;
   assign bus.alu_control = r_op;
   assign bus.busy      = r_busy;

`ifdef ALU_FLAG_RETURN_EN
   logic [2:0] r_flags;
   assign bus.rsp_flags = r_flags;
`else
   logic w_unused_flags;
   assign w_unused_flags = ^{bus.alu_zero, bus.alu_carry, bus.alu_overflow};
`endif

   // Operand regs are only rewritten on accept so the ALU inputs stay quiet when idle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_ptr       <= '0;
         r_grant     <= '0;
         r_rsp_valid <= '0;
         r_op        <= '0;
         r_rs1       <= '0;
         r_rs2       <= '0;
         r_rd        <= '0;
         r_busy      <= 1'b0;
`ifdef ALU_FLAG_RETURN_EN
         r_flags     <= '0;
`endif
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_any) begin
                  r_op    <= bus.req_op[4*int'(w_gidx) +: 4];
                  r_rs1   <= bus.req_rs1[XLEN*int'(w_gidx) +: XLEN];
                  r_rs2   <= bus.req_rs2[XLEN*int'(w_gidx) +: XLEN];
                  r_grant <= w_grant;
                  r_ptr   <= (int'(w_gidx) == NUM_REQ-1) ? '0 : w_gidx + 1'b1;
                  r_busy  <= 1'b1;
                  r_state <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               r_rd        <= bus.alu_rd;
               r_rsp_valid <= r_grant;
`ifdef ALU_FLAG_RETURN_EN
               r_flags     <= {is_addsub(r_op) & bus.alu_overflow,
                               is_addsub(r_op) & bus.alu_carry,
                               (bus.alu_rd == '0)};
`endif
               r_state     <= ST_RESP;
            end
            ST_RESP: begin
               if (w_rsp_hs) begin
                  r_rsp_valid <= '0;
                  r_rd        <= '0;
`ifdef ALU_FLAG_RETURN_EN
                  r_flags     <= '0;
`endif
                  r_busy      <= 1'b0;
                  r_state     <= ST_IDLE;
               end
            end
            default: begin
               r_rsp_valid <= '0;
               r_busy      <= 1'b0;
               r_state     <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
